// File: rtl/serial_pkg.sv
// Shared types for the serial slave.
//   state_t  : frame FSM state (IDLE between frames, SHIFT while bits move)
//   cnt_w()  : bit-counter width for a given word width; leaves room for
//              an optional trailing parity bit.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width for the default 8-bit build.
  localparam int BIT_CNT_W_DEF = $clog2(8 + 2);

  function automatic int cnt_w(input int data_w);
    return $clog2(data_w + 2);
  endfunction

endpackage

// File: rtl/serial_slave_ws_if.sv
// Parallel-side handshake bundle of the serial slave.
//   tx_data/tx_valid/tx_ready : word for the next outgoing frame
//   rx_data/rx_valid/rx_ready : last received word, held until accepted
// Modports: slave (the serial block), master (the register/command side).
interface serial_slave_ws_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/serial_slave_ws_sck_edge_sync.sv
// sck_edge_sync: brings the externally clocked sck/rxd pins into the clk
// domain and turns sck transitions into single-cycle strobes.
//   clk, res : system clock, synchronous active-high reset
//   sck, rxd : raw pins
//   rise/fall: one-cycle strobes on synced sck edges (never both at once)
//   idle     : synced sck has been high for IDLE_CYCLES cycles (saturated)
//   rxd_s    : rxd delayed by the same number of stages as sck, so it is
//              the data value seen at the moment rise is reported
module sck_edge_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = 16
) (
  input  logic clk,
  input  logic res,
  input  logic sck,
  input  logic rxd,
  output logic rise,
  output logic fall,
  output logic idle,
  output logic rxd_s
);
  localparam int IW = $clog2(IDLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sck_q, rxd_q;
  logic                   s, s_d;
  logic [IW-1:0]          idle_cnt;

  assign s = sck_q[SYNC_STAGES-1];

  // sck chain resets high (its idle level) so leaving reset never looks
  // like a falling edge; the idle counter starts saturated.
  always_ff @(posedge clk) begin
    if (res) begin
      sck_q    <= '1;
      rxd_q    <= '0;
      s_d      <= 1'b1;
      idle_cnt <= IW'(IDLE_CYCLES);
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], sck};
      rxd_q <= {rxd_q[SYNC_STAGES-2:0], rxd};
      s_d   <= s;
      if (!s)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(IDLE_CYCLES))
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign rise  = s & ~s_d;
  assign fall  = ~s & s_d;
  assign idle  = (idle_cnt == IW'(IDLE_CYCLES));
  assign rxd_s = rxd_q[SYNC_STAGES-1];

endmodule

// File: rtl/serial_slave_ws.sv
// serial_slave_ws: clk-synchronous serial slave on a 3-wire link.
// Receives rxd on sck rising edges and drives txd after sck falling edges,
// one DATA_W-bit frame at a time, with valid/ready on the parallel side.
//   clk, res    : system clock, synchronous active-high reset
//   sck, rxd    : link inputs (sck idles high)
//   txd         : link output
//   bus         : parallel tx/rx handshakes (slave modport)
//   busy        : frame in progress
//   rx_overrun  : sticky, a completed word was dropped (rx still full)
//   tx_underrun : pulse, frame started with no tx word (zeros sent)
//   frame_err   : pulse, link went idle mid-frame; partial word dropped
//   rx_perr     : pulse, parity mismatch on a completed frame
// Build option: SERIAL_SLAVE_WS_PARITY_EN appends an even-parity bit to
// every frame; without it rx_perr stays 0.
module serial_slave_ws
  import serial_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int LSB_FIRST   = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             sck,
  input  logic             rxd,
  output logic             txd,
  serial_slave_ws_if.slave bus,
  output logic             busy,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             frame_err,
  output logic             rx_perr
);
  localparam int CNT_W = cnt_w(DATA_W);
`ifdef SERIAL_SLAVE_WS_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif

  logic rise, fall, idle, rxd_s;

  sck_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_CYCLES (IDLE_CYCLES)
  ) u_sync (
    .clk   (clk),
    .res   (res),
    .sck   (sck),
    .rxd   (rxd),
    .rise  (rise),
    .fall  (fall),
    .idle  (idle),
    .rxd_s (rxd_s)
  );

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] tx_sr, rx_sr, load_frame;
  logic [DATA_W-1:0]     hold, rx_data_q;
  logic                  hold_full, rx_valid_q, done, tx_bit;

  // Both shift registers hold the frame in wire order (bit 0 goes first),
  // so bit order only matters when packing/unpacking the word.
  function automatic logic [FRAME_BITS-1:0] tx_frame(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] o;
    for (int i = 0; i < DATA_W; i++)
      o[i] = (LSB_FIRST != 0) ? w[i] : w[DATA_W-1-i];
`ifdef SERIAL_SLAVE_WS_PARITY_EN
    return {^w, o};
`else
    return o;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rx_word(input logic [DATA_W-1:0] f);
    logic [DATA_W-1:0] o;
    for (int i = 0; i < DATA_W; i++)
      o[i] = (LSB_FIRST != 0) ? f[i] : f[DATA_W-1-i];
    return o;
  endfunction

  // An empty hold register sends an all-zero frame (parity of 0 is 0).
  assign load_frame = tx_frame(hold_full ? hold : '0);

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      done        <= 1'b0;
      tx_bit      <= 1'b0;
      txd         <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      rx_perr     <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      rx_perr     <= 1'b0;
      // Extra output flop keeps txd latency at SYNC_STAGES+2 after the pin edge.
      txd         <= tx_bit;

      if (bus.tx_valid && !hold_full) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end

      if (rx_valid_q && bus.rx_ready)
        rx_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state       <= SHIFT;
            bit_cnt     <= '0;
            tx_bit      <= load_frame[0];
            tx_sr       <= load_frame >> 1;
            tx_underrun <= ~hold_full;
            // Only clear when full; an empty hold may be loading this cycle.
            if (hold_full)
              hold_full <= 1'b0;
          end
        end

        SHIFT: begin
          if (done) begin
            // Delivery one cycle after the last rise; a same-cycle accept
            // frees the slot so the new word is not counted as overrun.
            if (!rx_valid_q || bus.rx_ready) begin
              rx_data_q  <= rx_word(rx_sr[DATA_W-1:0]);
              rx_valid_q <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
`ifdef SERIAL_SLAVE_WS_PARITY_EN
            // Even parity: data plus parity bit must XOR to 0.
            rx_perr <= ^rx_sr;
`endif
            done    <= 1'b0;
            state   <= IDLE;
            bit_cnt <= '0;
            tx_bit  <= 1'b0;
          end else if (idle) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= '0;
            tx_bit    <= 1'b0;
          end else if (rise) begin
            rx_sr   <= {rxd_s, rx_sr[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CNT_W'(FRAME_BITS - 1))
              done <= 1'b1;
          end else if (fall) begin
            tx_bit <= tx_sr[0];
            tx_sr  <= tx_sr >> 1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready = ~hold_full;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign busy         = (state == SHIFT);

endmodule
